multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- FSM-based control unit for the multicycle RV32I core: one shared instruction/data memory port, one ALU and one write-back mux, each reused across cycles.
- Successor to the single-cycle decoder. Adds:
  - all six branch conditions;
  - LUI and AUIPC;
  - a variable-latency memory handshake;
  - sticky illegal-instruction trapping.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes and enables.

Parameters:
- OP_CODE_WIDTH, 7, opcode field width
- FUNCT3_WIDTH, 3, funct3 field width
- FUNCT7_WIDTH, 7, funct7 field width
- ALU_OP_WIDTH, 4, ALU operation select width
- STATE_WIDTH, 4, width of the debug state output

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous reset, active-high
- i_op_code  in  OP_CODE_WIDTH  opcode from instruction register
- i_funct3  in  FUNCT3_WIDTH  funct3 from instruction register
- i_funct7  in  FUNCT7_WIDTH  funct7 from instruction register
- i_alu_zero  in  1  ALU result == 0
- i_alu_lt  in  1  rs1 < rs2, signed
- i_alu_ltu  in  1  rs1 < rs2, unsigned
- i_mem_ready  in  1  memory completes the current request this cycle
- o_mem_req  out  1  memory request valid
- o_mem_wr_en  out  1  request is a write
- o_adr_sel  out  1  memory address source: 0 = PC, 1 = ALU-out register
- o_ir_wr_en  out  1  load instruction register and old-PC register
- o_pc_wr_en  out  1  PC update
- o_reg_file_wr_en  out  1  register file write
- o_imm_sel  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- o_alu_src_a_sel  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- o_alu_src_b_sel  out  2  00 rs2, 01 immediate, 10 constant 4
- o_alu_op  out  ALU_OP_WIDTH  ALU operation select
- o_wb_result_sel  out  2  00 memory data, 01 ALU-out register, 10 ALU combinational result
- o_illegal_instr  out  1  sticky trap flag
- o_state  out  STATE_WIDTH  current state, for debug

Behaviour:
- Reset:
  - Synchronous, active-high. State → FETCH next edge.
  - While i_reset is high, every output is 0.
  - o_illegal_instr clears only on reset.
  - Reset during a memory wait abandons the request; o_mem_req = 0 in the reset cycle.
- Output timing:
  - Outputs decode from the registered state (Moore), except:
    - o_pc_wr_en and o_ir_wr_en in FETCH depend on i_mem_ready;
    - o_pc_wr_en in BRANCH depends on the taken flag.
  - Unlisted outputs are 0.
  - o_imm_sel is decoded from the opcode in every state: S for store, B for branch, J for JAL, U for LUI/AUIPC, I otherwise.
- ALU op encoding:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
  - funct3 mapping is unchanged from the current core.
  - SUB only when opcode = R-type and funct7[5] = 1.
  - SRA when funct3 = 101 and funct7[5] = 1, for both R-type and I-type.
- FETCH:
  - mem_req = 1, adr_sel = 0; ALU computes PC + 4 (a = PC, b = 4, ADD, wb = 10).
  - Hold all request signals stable until i_mem_ready.
  - On ready: ir_wr_en = 1, pc_wr_en = 1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - ALU computes old PC + imm (branch/JAL target, latched into ALU-out).
  - Next state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH if funct3 ∉ {010, 011}, else TRAP
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UPPER
    - anything else → TRAP
- MEM_ADDR: a = rs1, b = imm, ADD. Next MEM_READ if load, else MEM_WRITE.
- MEM_READ: mem_req = 1, adr_sel = 1; wait for ready → MEM_WB.
- MEM_WB: wb = 00, reg_wr = 1 → FETCH.
- MEM_WRITE: mem_req = 1, mem_wr_en = 1, adr_sel = 1; wait for ready → FETCH.
- EXEC_R: a = rs1, b = rs2, decoded op → ALU_WB.
- EXEC_I: a = rs1, b = imm, decoded op → ALU_WB.
- ALU_WB: wb = 01, reg_wr = 1 → FETCH.
- BRANCH:
  - a = rs1, b = rs2, SUB, wb = 01; pc_wr_en = taken → FETCH.
  - taken per funct3:
    - 000: zero
    - 001: !zero
    - 100: lt
    - 101: !lt
    - 110: ltu
    - 111: !ltu
- JAL: a = old PC, b = 4, ADD, wb = 01, pc_wr_en = 1 (target from ALU-out) → ALU_WB (rd = old PC + 4).
- JALR: a = rs1, b = imm, ADD, wb = 10, pc_wr_en = 1 → LINK. Datapath clears bit 0.
- LINK:
  - a = old PC, b = 4, ADD, wb = 10, reg_wr = 1 → FETCH.
  - rs1 is read in JALR before rd is written, so rd == rs1 is safe.
- UPPER: a = zero if opcode[5] = 1 (LUI), else old PC (AUIPC); b = imm; ADD → ALU_WB.
- TRAP: o_illegal_instr = 1, all enables 0; stays in TRAP until reset.

Test Plan:
- Reset then release, i_mem_ready low for 5 cycles → mem_req = 1 throughout, ir_wr_en = pc_wr_en = 0; ready on 6th cycle → both pulse 1 for exactly one cycle, state = DECODE.
- R-type SUB (op 0110011, f3 000, f7 0100000), ready immediate → FETCH, DECODE, EXEC_R (alu_op 0001), ALU_WB (reg_wr 1, wb 01); 4 cycles total. Same fields with op 0010011 → alu_op 0000.
- LW then SW, each with ready latency 2 → LW: MEM_READ holds adr_sel 1 for 3 cycles, then MEM_WB wb 00 reg_wr 1. SW: mem_wr_en 1 for 3 cycles, no reg_wr.
- Branches:
  - BNE with zero = 0 → pc_wr_en 1 in BRANCH.
  - BNE with zero = 1 → pc_wr_en 0.
  - BGEU with ltu = 1 → pc_wr_en 0.
  - Branch with f3 010 → TRAP.
- JALR (op 1100111) → JALR: pc_wr 1, wb 10, src_a 10. Then LINK: reg_wr 1, src_a 01, src_b 10. Then FETCH.
- Opcode 0000000 → TRAP, illegal = 1 held 10 cycles with no enables; i_reset high 1 cycle → illegal = 0, state = FETCH. Reset asserted during a MEM_READ wait → mem_req drops the same cycle.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// FSM control unit for the multicycle RV32I core. A single memory port, one
// ALU and one write-back mux are shared across cycles; this block sequences
// them per instruction and drives every datapath mux select and write enable.
//
// Ports
//   i_clk, i_reset          clock (rising edge), synchronous active-high reset
//   i_op_code/funct3/funct7 fields from the instruction register
//   i_alu_zero/lt/ltu       ALU flags used for branch resolution
//   i_mem_ready             memory finishes the current request this cycle
//   o_mem_req/o_mem_wr_en   memory request valid / request is a write
//   o_adr_sel               memory address: 0 = PC, 1 = ALU-out register
//   o_ir_wr_en, o_pc_wr_en  IR/old-PC load, PC update
//   o_reg_file_wr_en        register file write
//   o_imm_sel               000 I, 001 S, 010 B, 011 J, 100 U
//   o_alu_src_a_sel         00 PC, 01 old PC, 10 rs1, 11 zero
//   o_alu_src_b_sel         00 rs2, 01 immediate, 10 constant 4
//   o_alu_op                ALU operation select
//   o_wb_result_sel         00 memory data, 01 ALU-out reg, 10 ALU result
//   o_illegal_instr         sticky trap flag, cleared only by reset
//   o_state                 current FSM state (debug)
//
// Memory handshake: a request is presented by holding o_mem_req (and the
// address/write selects) stable; the transfer completes in the cycle where
// o_mem_req and i_mem_ready are both high. There is no ready-before-valid
// requirement and the request is never withdrawn except by reset.
//
// State encoding on o_state: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3,
// MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10,
// JALR 11, LINK 12, UPPER 13, TRAP 14.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OP_CODE_WIDTH = 7,
    parameter int FUNCT3_WIDTH  = 3,
    parameter int FUNCT7_WIDTH  = 7,
    parameter int ALU_OP_WIDTH  = 4,
    parameter int STATE_WIDTH   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [OP_CODE_WIDTH-1:0] i_op_code,
    input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
    input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
    input  logic                     i_alu_zero,
    input  logic                     i_alu_lt,
    input  logic                     i_alu_ltu,
    input  logic                     i_mem_ready,
    output logic                     o_mem_req,
    output logic                     o_mem_wr_en,
    output logic                     o_adr_sel,
    output logic                     o_ir_wr_en,
    output logic                     o_pc_wr_en,
    output logic                     o_reg_file_wr_en,
    output logic [2:0]               o_imm_sel,
    output logic [1:0]               o_alu_src_a_sel,
    output logic [1:0]               o_alu_src_b_sel,
    output logic [ALU_OP_WIDTH-1:0]  o_alu_op,
    output logic [1:0]               o_wb_result_sel,
    output logic                     o_illegal_instr,
    output logic [STATE_WIDTH-1:0]   o_state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_LINK      = 4'd12;
    localparam logic [3:0] S_UPPER     = 4'd13;
    localparam logic [3:0] S_TRAP      = 4'd14;

    localparam logic [OP_CODE_WIDTH-1:0] OP_LOAD   = OP_CODE_WIDTH'(7'b0000011);
    localparam logic [OP_CODE_WIDTH-1:0] OP_STORE  = OP_CODE_WIDTH'(7'b0100011);
    localparam logic [OP_CODE_WIDTH-1:0] OP_R      = OP_CODE_WIDTH'(7'b0110011);
    localparam logic [OP_CODE_WIDTH-1:0] OP_I      = OP_CODE_WIDTH'(7'b0010011);
    localparam logic [OP_CODE_WIDTH-1:0] OP_BRANCH = OP_CODE_WIDTH'(7'b1100011);
    localparam logic [OP_CODE_WIDTH-1:0] OP_JAL    = OP_CODE_WIDTH'(7'b1101111);
    localparam logic [OP_CODE_WIDTH-1:0] OP_JALR   = OP_CODE_WIDTH'(7'b1100111);
    localparam logic [OP_CODE_WIDTH-1:0] OP_LUI    = OP_CODE_WIDTH'(7'b0110111);
    localparam logic [OP_CODE_WIDTH-1:0] OP_AUIPC  = OP_CODE_WIDTH'(7'b0010111);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    logic [3:0] state_q, state_d;
    logic       illegal_q;
    logic [3:0] alu_dec;
    logic [3:0] alu_op;
    logic       taken;
    logic       funct7_alt;
    logic       unused_funct7;

    assign funct7_alt    = i_funct7[5];
    assign unused_funct7 = ^i_funct7;

    // ALU operation for EXEC_R / EXEC_I. funct7[5] selects SUB only for
    // register-register ops (ADDI has no SUB form), but selects SRA for both.
    always_comb begin
        alu_dec = ALU_ADD;
        case (i_funct3)
            3'b000:  alu_dec = (i_op_code == OP_R && funct7_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = funct7_alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    end

    // Branch resolution from the SUB-comparison flags.
    always_comb begin
        taken = 1'b0;
        case (i_funct3)
            3'b000:  taken = i_alu_zero;
            3'b001:  taken = !i_alu_zero;
            3'b100:  taken = i_alu_lt;
            3'b101:  taken = !i_alu_lt;
            3'b110:  taken = i_alu_ltu;
            3'b111:  taken = !i_alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (i_mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (i_op_code)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = (i_funct3 == 3'b010 || i_funct3 == 3'b011)
                                                 ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (i_op_code == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (i_mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (i_mem_ready) state_d = S_FETCH;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALU_WB;
            S_JALR:      state_d = S_LINK;
            S_LINK:      state_d = S_FETCH;
            S_UPPER:     state_d = S_ALU_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Output decode. Moore from state_q except the FETCH/BRANCH enables;
    // reset forces everything low so an in-flight memory request is dropped
    // in the reset cycle itself.
    always_comb begin
        o_mem_req        = 1'b0;
        o_mem_wr_en      = 1'b0;
        o_adr_sel        = 1'b0;
        o_ir_wr_en       = 1'b0;
        o_pc_wr_en       = 1'b0;
        o_reg_file_wr_en = 1'b0;
        o_imm_sel        = 3'b000;
        o_alu_src_a_sel  = 2'b00;
        o_alu_src_b_sel  = 2'b00;
        alu_op           = ALU_ADD;
        o_wb_result_sel  = 2'b00;
        o_illegal_instr  = illegal_q;

        case (i_op_code)
            OP_STORE:         o_imm_sel = 3'b001;
            OP_BRANCH:        o_imm_sel = 3'b010;
            OP_JAL:           o_imm_sel = 3'b011;
            OP_LUI, OP_AUIPC: o_imm_sel = 3'b100;
            default:          o_imm_sel = 3'b000;
        endcase

        case (state_q)
            S_FETCH: begin
                o_mem_req       = 1'b1;
                o_ir_wr_en      = i_mem_ready;
                o_pc_wr_en      = i_mem_ready;
                o_alu_src_a_sel = 2'b00;
                o_alu_src_b_sel = 2'b10;
                o_wb_result_sel = 2'b10;
            end
            S_DECODE: begin
                o_alu_src_a_sel = 2'b01;
                o_alu_src_b_sel = 2'b01;
            end
            S_MEM_ADDR: begin
                o_alu_src_a_sel = 2'b10;
                o_alu_src_b_sel = 2'b01;
            end
            S_MEM_READ: begin
                o_mem_req = 1'b1;
                o_adr_sel = 1'b1;
            end
            S_MEM_WB: begin
                o_wb_result_sel  = 2'b00;
                o_reg_file_wr_en = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_req   = 1'b1;
                o_mem_wr_en = 1'b1;
                o_adr_sel   = 1'b1;
            end
            S_EXEC_R: begin
                o_alu_src_a_sel = 2'b10;
                o_alu_src_b_sel = 2'b00;
                alu_op          = alu_dec;
            end
            S_EXEC_I: begin
                o_alu_src_a_sel = 2'b10;
                o_alu_src_b_sel = 2'b01;
                alu_op          = alu_dec;
            end
            S_ALU_WB: begin
                o_wb_result_sel  = 2'b01;
                o_reg_file_wr_en = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a_sel = 2'b10;
                o_alu_src_b_sel = 2'b00;
                alu_op          = ALU_SUB;
                o_wb_result_sel = 2'b01;
                o_pc_wr_en      = taken;
            end
            S_JAL: begin
                // PC takes the target latched in ALU-out during DECODE while
                // the ALU forms the link value old PC + 4.
                o_alu_src_a_sel = 2'b01;
                o_alu_src_b_sel = 2'b10;
                o_wb_result_sel = 2'b01;
                o_pc_wr_en      = 1'b1;
            end
            S_JALR: begin
                o_alu_src_a_sel = 2'b10;
                o_alu_src_b_sel = 2'b01;
                o_wb_result_sel = 2'b10;
                o_pc_wr_en      = 1'b1;
            end
            S_LINK: begin
                o_alu_src_a_sel  = 2'b01;
                o_alu_src_b_sel  = 2'b10;
                o_wb_result_sel  = 2'b10;
                o_reg_file_wr_en = 1'b1;
            end
            S_UPPER: begin
                // opcode bit 5 distinguishes LUI (zero base) from AUIPC.
                o_alu_src_a_sel = i_op_code[5] ? 2'b11 : 2'b01;
                o_alu_src_b_sel = 2'b01;
            end
            S_TRAP: begin
                o_illegal_instr = 1'b1;
            end
            default: begin
                o_illegal_instr = 1'b1;
            end
        endcase

        if (i_reset) begin
            o_mem_req        = 1'b0;
            o_mem_wr_en      = 1'b0;
            o_adr_sel        = 1'b0;
            o_ir_wr_en       = 1'b0;
            o_pc_wr_en       = 1'b0;
            o_reg_file_wr_en = 1'b0;
            o_imm_sel        = 3'b000;
            o_alu_src_a_sel  = 2'b00;
            o_alu_src_b_sel  = 2'b00;
            alu_op           = ALU_ADD;
            o_wb_result_sel  = 2'b00;
            o_illegal_instr  = 1'b0;
        end
    end

    assign o_alu_op = ALU_OP_WIDTH'(alu_op);
    assign o_state  = i_reset ? '0 : STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Per-cycle vector table: each record holds the inputs for one cycle and the
// complete expected output word. Inputs change on the falling edge, the
// expected word is queued, and outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       zero, lt, ltu, rdy;

  logic       mem_req, mem_wr_en, adr_sel, ir_wr_en, pc_wr_en, reg_wr_en;
  logic [2:0] imm_sel;
  logic [1:0] src_a, src_b, wb_sel;
  logic [3:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  multicycle_control_unit dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_op_code        (op),
    .i_funct3         (f3),
    .i_funct7         (f7),
    .i_alu_zero       (zero),
    .i_alu_lt         (lt),
    .i_alu_ltu        (ltu),
    .i_mem_ready      (rdy),
    .o_mem_req        (mem_req),
    .o_mem_wr_en      (mem_wr_en),
    .o_adr_sel        (adr_sel),
    .o_ir_wr_en       (ir_wr_en),
    .o_pc_wr_en       (pc_wr_en),
    .o_reg_file_wr_en (reg_wr_en),
    .o_imm_sel        (imm_sel),
    .o_alu_src_a_sel  (src_a),
    .o_alu_src_b_sel  (src_b),
    .o_alu_op         (alu_op),
    .o_wb_result_sel  (wb_sel),
    .o_illegal_instr  (illegal),
    .o_state          (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic        lt;
    logic        ltu;
    logic [1:0]  rdy;   // 2 = random, the design must not care
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] exp_q[$];
  int          checks;
  int          failures;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;

  // Expected output word, fields in the order of the actual-output packing.
  function automatic logic [23:0] ev(int st, int ill, int req, int wr, int adr,
                                     int ir, int pc, int rw, int imm, int a,
                                     int b, int aop, int wb);
    return {st[3:0], ill[0], req[0], wr[0], adr[0], ir[0], pc[0], rw[0],
            imm[2:0], a[1:0], b[1:0], aop[3:0], wb[1:0]};
  endfunction

  function automatic logic [23:0] actual();
    return {state, illegal, mem_req, mem_wr_en, adr_sel, ir_wr_en, pc_wr_en,
            reg_wr_en, imm_sel, src_a, src_b, alu_op, wb_sel};
  endfunction

  task automatic instr(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7);
    cur_op = o;
    cur_f3 = a3;
    cur_f7 = a7;
  endtask

  task automatic v(input string n, input logic r, input logic z, input logic l,
                   input logic lu, input logic [1:0] rd, input logic [23:0] e);
    vec_t t;
    t.name = n; t.rst = r; t.op = cur_op; t.f3 = cur_f3; t.f7 = cur_f7;
    t.z = z; t.lt = l; t.ltu = lu; t.rdy = rd; t.exp = e;
    vecs.push_back(t);
  endtask

  // FETCH with immediate ready followed by DECODE.
  task automatic fd(input string n, input int imm);
    v({n, "_fetch"}, 0, 0, 0, 0, 1, ev(0, 0, 1, 0, 0, 1, 1, 0, imm, 0, 2, 0, 2));
    v({n, "_decode"}, 0, 0, 0, 0, 2, ev(1, 0, 0, 0, 0, 0, 0, 0, imm, 1, 1, 0, 0));
  endtask

  task automatic alu_wb(input string n, input int imm);
    v({n, "_alu_wb"}, 0, 0, 0, 0, 2, ev(8, 0, 0, 0, 0, 0, 0, 1, imm, 0, 0, 0, 1));
  endtask

  task automatic trap_and_reset(input string n, input int imm);
    v({n, "_trap_entry"}, 0, 0, 0, 0, 2, ev(14, 1, 0, 0, 0, 0, 0, 0, imm, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      v({n, "_trap_hold"}, 0, 1, 1, 1, 2, ev(14, 1, 0, 0, 0, 0, 0, 0, imm, 0, 0, 0, 0));
    v({n, "_trap_reset"}, 1, 0, 0, 0, 2, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v({n, "_after_reset"}, 0, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0, 0, imm, 0, 2, 0, 2));
  endtask

  task automatic compare(input string n);
    logic [23:0] e;
    logic [23:0] g;
    g = actual();
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%h (state=%0d) required=%h (state=%0d)", n, g, g[23:20], e, e[23:20]);
    end
  endtask

  task automatic drive_vec(input vec_t t);
    @(negedge clk);
    rst  = t.rst;
    op   = t.op;
    f3   = t.f3;
    f7   = t.f7;
    zero = t.z;
    lt   = t.lt;
    ltu  = t.ltu;
    rdy  = (t.rdy == 2'd2) ? 1'($urandom_range(0, 1)) : t.rdy[0];
    exp_q.push_back(t.exp);
    #1;
    compare(t.name);
  endtask

  task automatic build_table();
    // reset
    instr(7'b0110011, 3'b000, 7'b0100000);
    v("reset0", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v("reset1", 1, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fetch wait then R-type SUB
    for (int k = 0; k < 5; k++)
      v("fetch_wait", 0, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2));
    fd("sub", 0);
    v("sub_exec_r", 0, 0, 0, 0, 2, ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
    alu_wb("sub", 0);
    // same fields as I-type: ADD, not SUB
    instr(7'b0010011, 3'b000, 7'b0100000);
    fd("addi", 0);
    v("addi_exec_i", 0, 0, 0, 0, 2, ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    alu_wb("addi", 0);
    // SRA (R), SRL (I), SLTU (R), AND (I)
    instr(7'b0110011, 3'b101, 7'b0100000);
    fd("sra", 0);
    v("sra_exec_r", 0, 0, 0, 0, 2, ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 7, 0));
    alu_wb("sra", 0);
    instr(7'b0010011, 3'b101, 7'b0000000);
    fd("srli", 0);
    v("srli_exec_i", 0, 0, 0, 0, 2, ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 6, 0));
    alu_wb("srli", 0);
    instr(7'b0110011, 3'b011, 7'b0000000);
    fd("sltu", 0);
    v("sltu_exec_r", 0, 0, 0, 0, 2, ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 4, 0));
    alu_wb("sltu", 0);
    instr(7'b0010011, 3'b111, 7'b0000000);
    fd("andi", 0);
    v("andi_exec_i", 0, 0, 0, 0, 2, ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 9, 0));
    alu_wb("andi", 0);
    // LW, latency 2
    instr(7'b0000011, 3'b010, 7'b0000000);
    fd("lw", 0);
    v("lw_mem_addr", 0, 0, 0, 0, 2, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    v("lw_mem_read", 0, 0, 0, 0, 0, ev(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    v("lw_mem_read", 0, 0, 0, 0, 0, ev(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    v("lw_mem_read", 0, 0, 0, 0, 1, ev(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    v("lw_mem_wb", 0, 0, 0, 0, 2, ev(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // SW, latency 2
    instr(7'b0100011, 3'b010, 7'b0000000);
    fd("sw", 1);
    v("sw_mem_addr", 0, 0, 0, 0, 2, ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    v("sw_mem_write", 0, 0, 0, 0, 0, ev(5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    v("sw_mem_write", 0, 0, 0, 0, 0, ev(5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    v("sw_mem_write", 0, 0, 0, 0, 1, ev(5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    // branches
    instr(7'b1100011, 3'b001, 7'b0000000);
    fd("bne_nz", 2);
    v("bne_nz_branch", 0, 0, 0, 0, 2, ev(9, 0, 0, 0, 0, 0, 1, 0, 2, 2, 0, 1, 1));
    fd("bne_z", 2);
    v("bne_z_branch", 0, 1, 0, 0, 2, ev(9, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 1));
    instr(7'b1100011, 3'b111, 7'b0000000);
    fd("bgeu_ltu", 2);
    v("bgeu_ltu_branch", 0, 0, 1, 1, 2, ev(9, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 1));
    instr(7'b1100011, 3'b100, 7'b0000000);
    fd("blt_lt", 2);
    v("blt_lt_branch", 0, 0, 1, 0, 2, ev(9, 0, 0, 0, 0, 0, 1, 0, 2, 2, 0, 1, 1));
    instr(7'b1100011, 3'b000, 7'b0000000);
    fd("beq_z", 2);
    v("beq_z_branch", 0, 1, 0, 0, 2, ev(9, 0, 0, 0, 0, 0, 1, 0, 2, 2, 0, 1, 1));
    // JAL
    instr(7'b1101111, 3'b000, 7'b0000000);
    fd("jal", 3);
    v("jal_jal", 0, 0, 0, 0, 2, ev(10, 0, 0, 0, 0, 0, 1, 0, 3, 1, 2, 0, 1));
    alu_wb("jal", 3);
    // JALR
    instr(7'b1100111, 3'b000, 7'b0000000);
    fd("jalr", 0);
    v("jalr_jalr", 0, 0, 0, 0, 2, ev(11, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1, 0, 2));
    v("jalr_link", 0, 0, 0, 0, 2, ev(12, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 2));
    // LUI / AUIPC
    instr(7'b0110111, 3'b000, 7'b0000000);
    fd("lui", 4);
    v("lui_upper", 0, 0, 0, 0, 2, ev(13, 0, 0, 0, 0, 0, 0, 0, 4, 3, 1, 0, 0));
    alu_wb("lui", 4);
    instr(7'b0010111, 3'b000, 7'b0000000);
    fd("auipc", 4);
    v("auipc_upper", 0, 0, 0, 0, 2, ev(13, 0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0));
    alu_wb("auipc", 4);
    // illegal branch funct3, then illegal opcode
    instr(7'b1100011, 3'b010, 7'b0000000);
    fd("bad_branch", 2);
    trap_and_reset("bad_branch", 2);
    instr(7'b0000000, 3'b000, 7'b0000000);
    v("bad_op_fetch", 0, 0, 0, 0, 1, ev(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2, 0, 2));
    v("bad_op_decode", 0, 0, 0, 0, 2, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    trap_and_reset("bad_op", 0);
    // reset during a MEM_READ wait
    instr(7'b0000011, 3'b010, 7'b0000000);
    v("rst_lw_fetch", 0, 0, 0, 0, 1, ev(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2, 0, 2));
    v("rst_lw_decode", 0, 0, 0, 0, 2, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    v("rst_lw_mem_addr", 0, 0, 0, 0, 2, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    v("rst_lw_mem_read", 0, 0, 0, 0, 0, ev(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    v("rst_lw_reset", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v("rst_lw_refetch", 0, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2));
  endtask

  // ---------------- main ----------------
  initial begin
    int lat;
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    op   = '0;
    f3   = '0;
    f7   = '0;
    zero = 1'b0;
    lt   = 1'b0;
    ltu  = 1'b0;
    rdy  = 1'b0;

    build_table();
    for (int i = 0; i < vecs.size(); i++) drive_vec(vecs[i]);

    // Hand-written: random-latency fetches; request must hold until ready,
    // enables pulse once, then DECODE within one cycle.
    op = 7'b0110011;
    f3 = 3'b000;
    f7 = 7'b0000000;
    for (int n = 0; n < 4; n++) begin
      lat = $urandom_range(0, 6);
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        rdy = 1'b0;
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2));
        #1;
        compare("rand_fetch_wait");
      end
      @(negedge clk);
      rdy = 1'b1;
      exp_q.push_back(ev(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2, 0, 2));
      #1;
      compare("rand_fetch_ready");
      @(negedge clk);
      rdy = 1'b0;
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      #1;
      compare("rand_decode");
      @(negedge clk);
      exp_q.push_back(ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
      #1;
      compare("rand_exec_add");
      @(negedge clk);
      exp_q.push_back(ev(8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      #1;
      compare("rand_alu_wb");
    end

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
